// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback stage.
package wb_pkg;

  localparam int REG_W        = 5;
  localparam int DATA_W       = 32;
  localparam int FIFO_DEPTH   = 2;
  localparam int STARVE_LIMIT = 3;
  localparam int STAMP_W      = 3;
  localparam int NUM_REGS     = 1 << REG_W;
  localparam int CNT_W        = 2;
  localparam int STREAK_W     = 2;
  localparam int DROP_W       = 8;

  typedef struct packed {
    logic [REG_W-1:0]   rd;
    logic [DATA_W-1:0]  data;
    logic [STAMP_W-1:0] stamp;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_MEM  = 2'd1,
    GRANT_ALU  = 2'd2
  } grant_e;

  // Stamps wrap, so "a is older than b" means b is a small positive distance ahead of a.
  function automatic logic stamp_older(input logic [STAMP_W-1:0] a,
                                       input logic [STAMP_W-1:0] b);
    logic [STAMP_W-1:0] diff;
    diff = b - a;
    return (diff != {STAMP_W{1'b0}}) && !diff[STAMP_W-1];
  endfunction

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic             v,
                                                    input logic [REG_W-1:0] rd);
    logic [NUM_REGS-1:0] m;
    m = {NUM_REGS{1'b0}};
    if (v) begin
      m[rd] = 1'b1;
    end else begin
      m = {NUM_REGS{1'b0}};
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Two-entry shift FIFO holding writeback entries; exposes every slot's rd
// so the top can build the busy mask.
module wb_fifo
  import wb_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push,
  input  logic                              pop,
  input  wb_entry_t                         push_entry,
  output wb_entry_t                         head,
  output logic [CNT_W-1:0]                  count,
  output logic [FIFO_DEPTH-1:0]             entry_valid,
  output logic [FIFO_DEPTH-1:0][REG_W-1:0]  entry_rd
);

  wb_entry_t        slot0_r, slot1_r, slot0_s, slot1_s;
  logic [CNT_W-1:0] count_r, count_s;

  // Next slot contents: slot0 is always the head; a pop shifts slot1 down.
  always_comb begin
    slot0_s = slot0_r;
    slot1_s = slot1_r;
    count_s = count_r;
    case ({push, pop})
      2'b10: begin
        if (count_r == CNT_W'(0)) begin
          slot0_s = push_entry;
        end else begin
          slot1_s = push_entry;
        end
        count_s = count_r + CNT_W'(1);
      end
      2'b01: begin
        slot0_s = slot1_r;
        slot1_s = '0;
        count_s = count_r - CNT_W'(1);
      end
      2'b11: begin
        if (count_r == CNT_W'(1)) begin
          slot0_s = push_entry;
        end else begin
          slot0_s = slot1_r;
          slot1_s = push_entry;
        end
      end
      default: count_s = count_r;
    endcase
  end

  // Slot and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_r <= '0;
      slot1_r <= '0;
      count_r <= CNT_W'(0);
    end else begin
      slot0_r <= slot0_s;
      slot1_r <= slot1_s;
      count_r <= count_s;
    end
  end

  assign head           = slot0_r;
  assign count          = count_r;
  assign entry_valid[0] = (count_r != CNT_W'(0));
  assign entry_valid[1] = (count_r == CNT_W'(FIFO_DEPTH));
  assign entry_rd[0]    = slot0_r.rd;
  assign entry_rd[1]    = slot1_r.rd;

endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU and load results into the single register-file write port,
// with accept-order stamps, a starvation guard and r0 write discard.
module regfile_writeback
  import wb_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [REG_W-1:0]    alu_rd,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [REG_W-1:0]    mem_rd,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                reg_write,
  output logic [REG_W-1:0]    reg_dest,
  output logic [DATA_W-1:0]   write_data,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [DROP_W-1:0]   drop_count
);

  logic                ready_en_r;
  logic [STAMP_W-1:0]  stamp_r, stamp_s;
  logic [STREAK_W-1:0] streak_r, streak_s;
  logic                reg_write_r;
  logic [REG_W-1:0]    reg_dest_r;
  logic [DATA_W-1:0]   write_data_r;
  logic [DROP_W-1:0]   drop_count_r;

  logic                alu_push_s, mem_push_s, alu_pop_s, mem_pop_s;
  logic                alu_ne_s, mem_ne_s;
  wb_entry_t           alu_entry_s, mem_entry_s, alu_head_s, mem_head_s, pop_entry_s;
  logic [CNT_W-1:0]    alu_count_s, mem_count_s;
  logic [FIFO_DEPTH-1:0]            alu_evalid_s, mem_evalid_s;
  logic [FIFO_DEPTH-1:0][REG_W-1:0] alu_erd_s, mem_erd_s;
  grant_e              grant_s;
  logic [NUM_REGS-1:0] busy_s;

  // ready_en_r keeps both channels closed until the first edge after reset release.
  assign alu_ready = ready_en_r && (alu_count_s < CNT_W'(FIFO_DEPTH));
  assign mem_ready = ready_en_r && (mem_count_s < CNT_W'(FIFO_DEPTH));
  assign alu_push_s = alu_valid && alu_ready;
  assign mem_push_s = mem_valid && mem_ready;
  assign alu_ne_s   = (alu_count_s != CNT_W'(0));
  assign mem_ne_s   = (mem_count_s != CNT_W'(0));

  // Stamp assignment: mem takes the older number on a shared acceptance edge.
  always_comb begin
    mem_entry_s = '{rd: mem_rd, data: mem_data, stamp: stamp_r};
    alu_entry_s = '{rd: alu_rd, data: alu_data, stamp: stamp_r + STAMP_W'(mem_push_s)};
    stamp_s     = stamp_r + STAMP_W'(mem_push_s) + STAMP_W'(alu_push_s);
  end

  wb_fifo u_alu_fifo (
    .clk(clk), .rst_n(rst_n), .push(alu_push_s), .pop(alu_pop_s),
    .push_entry(alu_entry_s), .head(alu_head_s), .count(alu_count_s),
    .entry_valid(alu_evalid_s), .entry_rd(alu_erd_s)
  );

  wb_fifo u_mem_fifo (
    .clk(clk), .rst_n(rst_n), .push(mem_push_s), .pop(mem_pop_s),
    .push_entry(mem_entry_s), .head(mem_head_s), .count(mem_count_s),
    .entry_valid(mem_evalid_s), .entry_rd(mem_erd_s)
  );

  // Arbiter: same-rd ordering first, then starvation guard, then mem priority.
  always_comb begin
    grant_s = GRANT_NONE;
    if (alu_ne_s && mem_ne_s) begin
      if ((alu_head_s.rd == mem_head_s.rd) && (alu_head_s.rd != REG_W'(0))) begin
        if (stamp_older(alu_head_s.stamp, mem_head_s.stamp)) begin
          grant_s = GRANT_ALU;
        end else begin
          grant_s = GRANT_MEM;
        end
      end else if (streak_r == STREAK_W'(STARVE_LIMIT)) begin
        grant_s = GRANT_ALU;
      end else begin
        grant_s = GRANT_MEM;
      end
    end else if (mem_ne_s) begin
      grant_s = GRANT_MEM;
    end else if (alu_ne_s) begin
      grant_s = GRANT_ALU;
    end else begin
      grant_s = GRANT_NONE;
    end

    streak_s = streak_r;
    case (grant_s)
      GRANT_ALU: streak_s = STREAK_W'(0);
      GRANT_MEM: begin
        if (alu_ne_s && (streak_r != STREAK_W'(STARVE_LIMIT))) begin
          streak_s = streak_r + STREAK_W'(1);
        end else begin
          streak_s = streak_r;
        end
      end
      default: streak_s = streak_r;
    endcase
  end

  assign alu_pop_s   = (grant_s == GRANT_ALU);
  assign mem_pop_s   = (grant_s == GRANT_MEM);
  assign pop_entry_s = alu_pop_s ? alu_head_s : mem_head_s;

  // Busy mask covers buffered entries plus the write currently on the port.
  always_comb begin
    busy_s = rd_onehot(reg_write_r, reg_dest_r);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      busy_s = busy_s | rd_onehot(alu_evalid_s[i], alu_erd_s[i])
                      | rd_onehot(mem_evalid_s[i], mem_erd_s[i]);
    end
    busy_s[0] = 1'b0;
  end

  // Control state and the registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_r   <= 1'b0;
      stamp_r      <= STAMP_W'(0);
      streak_r     <= STREAK_W'(0);
      reg_write_r  <= 1'b0;
      reg_dest_r   <= REG_W'(0);
      write_data_r <= DATA_W'(0);
      drop_count_r <= DROP_W'(0);
    end else begin
      ready_en_r <= 1'b1;
      stamp_r    <= stamp_s;
      streak_r   <= streak_s;
      if ((grant_s != GRANT_NONE) && (pop_entry_s.rd != REG_W'(0))) begin
        reg_write_r  <= 1'b1;
        reg_dest_r   <= pop_entry_s.rd;
        write_data_r <= pop_entry_s.data;
      end else begin
        reg_write_r  <= 1'b0;
      end
      if ((grant_s != GRANT_NONE) && (pop_entry_s.rd == REG_W'(0))
          && (drop_count_r != {DROP_W{1'b1}})) begin
        drop_count_r <= drop_count_r + DROP_W'(1);
      end else begin
        drop_count_r <= drop_count_r;
      end
    end
  end

  assign reg_write  = reg_write_r;
  assign reg_dest   = reg_dest_r;
  assign write_data = write_data_r;
  assign busy_mask  = busy_s;
  assign drop_count = drop_count_r;

endmodule
